// File: rtl/alu_exec_ctrl_if.sv
// Bundle of instruction, ALU and writeback signals between the decode side,
// the combinational ALU and alu_exec_ctrl. Signal names follow the block's port list.
interface alu_exec_ctrl_if #(
    parameter int WordWidth = 32
);
    // Handshake: an instruction moves on a rising edge where in_Valid and
    // out_Ready are both high. The source holds all fields steady until then.
    // out_Ready is high only in IDLE, so in_Valid in other states is ignored.
    logic                 in_Valid;
    logic                 out_Ready;
    logic [3:0]           in_Cond;
    logic [3:0]           in_Opcode;
    logic                 in_SetFlags;
    logic [3:0]           in_Rd;
    logic [WordWidth-1:0] in_RnVal;
    logic [WordWidth-1:0] in_Op2;
    logic                 in_ShCarry;
    logic [WordWidth-1:0] out_AluRn;
    logic [WordWidth-1:0] out_AluOp2;
    logic                 out_AluCarry;
    logic [3:0]           out_AluOpcode;
    logic [WordWidth-1:0] in_AluY;
    logic [3:0]           in_AluCNZV;
    logic                 in_FlagLoad;
    logic [3:0]           in_FlagData;
    logic [3:0]           out_Flags;
    logic                 out_WbEn;
    logic [3:0]           out_WbRd;
    logic [WordWidth-1:0] out_WbData;
    logic                 out_Done;
    logic [1:0]           out_DbgState;

    modport slave (
        input  in_Valid, in_Cond, in_Opcode, in_SetFlags, in_Rd, in_RnVal, in_Op2,
               in_ShCarry, in_AluY, in_AluCNZV, in_FlagLoad, in_FlagData,
        output out_Ready, out_AluRn, out_AluOp2, out_AluCarry, out_AluOpcode,
               out_Flags, out_WbEn, out_WbRd, out_WbData, out_Done, out_DbgState
    );

    modport master (
        output in_Valid, in_Cond, in_Opcode, in_SetFlags, in_Rd, in_RnVal, in_Op2,
               in_ShCarry, in_AluY, in_AluCNZV, in_FlagLoad, in_FlagData,
        input  out_Ready, out_AluRn, out_AluOp2, out_AluCarry, out_AluOpcode,
               out_Flags, out_WbEn, out_WbRd, out_WbData, out_Done, out_DbgState
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: IDLE -> EXEC -> WB per instruction, evaluates the ARM
// condition against the owned NZCV register and issues a one-cycle writeback.
module alu_exec_ctrl #(
    parameter int WordWidth = 32
) (
    input logic           in_Clk,
    input logic           in_Rst,
    alu_exec_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [3:0]           r_cond;
    logic [3:0]           r_opcode;
    logic                 r_set_flags;
    logic [3:0]           r_rd;
    logic [WordWidth-1:0] r_rn;
    logic [WordWidth-1:0] r_op2;
    logic                 r_sh_carry;
    logic [3:0]           r_flags;
    logic                 r_wb_en;
    logic [WordWidth-1:0] r_wb_data;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_exec;
    logic                 w_pass;
    logic                 w_is_test;
    logic                 w_is_arith;
    logic                 w_use_flag_c;
    logic                 w_flag_upd;
    logic [3:0]           w_alu_flags;
    logic                 w_n, w_z, w_c, w_v;

    assign w_accept = bus.in_Valid && (r_state == ST_IDLE);
    assign w_exec   = (r_state == ST_EXEC);

    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_WB;
            ST_WB:   w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    always_comb begin
        w_pass = 1'b0;
        case (r_cond)
            4'd0:    w_pass = w_z;
            4'd1:    w_pass = !w_z;
            4'd2:    w_pass = w_c;
            4'd3:    w_pass = !w_c;
            4'd4:    w_pass = w_n;
            4'd5:    w_pass = !w_n;
            4'd6:    w_pass = w_v;
            4'd7:    w_pass = !w_v;
            4'd8:    w_pass = w_c && !w_z;
            4'd9:    w_pass = !w_c || w_z;
            4'd10:   w_pass = (w_n == w_v);
            4'd11:   w_pass = (w_n != w_v);
            4'd12:   w_pass = !w_z && (w_n == w_v);
            4'd13:   w_pass = w_z || (w_n != w_v);
            4'd14:   w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    // TST/TEQ/CMP/CMN occupy 8..11; of those only CMP/CMN are arithmetic.
    assign w_is_test    = (r_opcode[3:2] == 2'b10);
    assign w_is_arith   = ((r_opcode >= 4'd2) && (r_opcode <= 4'd7)) || (w_is_test && r_opcode[1]);
    assign w_use_flag_c = (r_opcode >= 4'd5) && (r_opcode <= 4'd7);
    assign w_flag_upd   = w_exec && w_pass && (r_set_flags || w_is_test);

    // ALU reports {C,N,Z,V}; the architectural register is {N,Z,C,V}.
    assign w_alu_flags = {bus.in_AluCNZV[2], bus.in_AluCNZV[1], bus.in_AluCNZV[3],
                          w_is_arith ? bus.in_AluCNZV[0] : w_v};

    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) begin
            r_cond      <= 4'd0;
            r_opcode    <= 4'd0;
            r_set_flags <= 1'b0;
            r_rd        <= 4'd0;
            r_rn        <= '0;
            r_op2       <= '0;
            r_sh_carry  <= 1'b0;
        end else if (w_accept) begin
            r_cond      <= bus.in_Cond;
            r_opcode    <= bus.in_Opcode;
            r_set_flags <= bus.in_SetFlags;
            r_rd        <= bus.in_Rd;
            r_rn        <= bus.in_RnVal;
            r_op2       <= bus.in_Op2;
            r_sh_carry  <= bus.in_ShCarry;
        end
    end

    // A direct flag load overrides a coincident instruction flag update.
    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst)                r_flags <= 4'd0;
        else if (bus.in_FlagLoad)  r_flags <= bus.in_FlagData;
        else if (w_flag_upd)       r_flags <= w_alu_flags;
    end

    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) begin
            r_wb_en   <= 1'b0;
            r_done    <= 1'b0;
            r_wb_data <= '0;
        end else begin
            r_wb_en <= w_exec && w_pass && !w_is_test;
            r_done  <= w_exec;
            if (w_exec) r_wb_data <= bus.in_AluY;
        end
    end

    assign bus.out_Ready     = (r_state == ST_IDLE);
    assign bus.out_AluRn     = r_rn;
    assign bus.out_AluOp2    = r_op2;
    assign bus.out_AluOpcode = r_opcode;
    assign bus.out_AluCarry  = w_use_flag_c ? w_c : r_sh_carry;
    assign bus.out_Flags     = r_flags;
    assign bus.out_WbEn      = r_wb_en;
    assign bus.out_WbRd      = r_rd;
    assign bus.out_WbData    = r_wb_data;
    assign bus.out_Done      = r_done;
    assign bus.out_DbgState  = r_state;
endmodule
